// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared widths, constants, FSM state and packed result type for the fp16 add/normalise stage
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 11;

    localparam logic [EXP_W-1:0] EXP_INF = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-2:0] frac;
    } fp16_t;

endpackage

// File: rtl/fp16_mag_addsub.sv
// rtl/fp16_mag_addsub.sv - combinational magnitude add/sub of two aligned mantissas with result sign
module fp16_mag_addsub
    import fp16_pkg::*;
(
    input  logic             sign_a_i,
    input  logic             sign_b_i,
    input  logic [MAN_W-1:0] man_a_i,
    input  logic [MAN_W-1:0] man_b_i,
    output logic [MAN_W:0]   mag_o,
    output logic             sign_o,
    output logic             carry_o,
    output logic             eq_o
);

    logic same_sign;

    assign same_sign = (sign_a_i == sign_b_i);

    // Same signs add magnitudes; differing signs subtract smaller from larger and keep the larger's sign
    always_comb begin
        mag_o  = '0;
        sign_o = sign_a_i;
        if (same_sign) begin
            mag_o  = {1'b0, man_a_i} + {1'b0, man_b_i};
            sign_o = sign_a_i;
        end else if (man_a_i >= man_b_i) begin
            mag_o  = {1'b0, man_a_i} - {1'b0, man_b_i};
            sign_o = sign_a_i;
        end else begin
            mag_o  = {1'b0, man_b_i} - {1'b0, man_a_i};
            sign_o = sign_b_i;
        end
    end

    assign carry_o = mag_o[MAN_W];
    assign eq_o    = !same_sign && (man_a_i == man_b_i);

endmodule

// File: rtl/fp16_add_norm.sv
// rtl/fp16_add_norm.sv - add/subtract, iterative normalise and pack stage; FP16_ADD_ROUND_EN enables round half-up on carry
module fp16_add_norm
    import fp16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             sc1,
    input  logic             sc2,
    input  logic [EXP_W-1:0] e3,
    input  logic [MAN_W-1:0] mc1,
    input  logic [MAN_W-1:0] mc2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             overflow,
    output logic             underflow,
    output logic             zero
);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    fp16_t            result_q;
    logic             ovf_q, unf_q, zero_q;
    logic             special_q;
    logic             op_sub_q, sc1_q, sc2_q;
    logic [EXP_W-1:0] e3_q;
    logic [MAN_W-1:0] mc1_q, mc2_q;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W-1:0] man_q;

    logic [MAN_W:0]   sum;
    logic             sum_sign, sum_carry, sum_eq;
    logic [1:0]       add_inc;
    logic [MAN_W-1:0] add_man;
    logic [EXP_W:0]   add_exp;
    logic             add_ovf, add_zero;

    fp16_mag_addsub u_mag (
        .sign_a_i (sc1_q),
        .sign_b_i (sc2_q ^ op_sub_q),
        .man_a_i  (mc1_q),
        .man_b_i  (mc2_q),
        .mag_o    (sum),
        .sign_o   (sum_sign),
        .carry_o  (sum_carry),
        .eq_o     (sum_eq)
    );

`ifdef FP16_ADD_ROUND_EN
    logic [MAN_W:0] rnd;
`endif

    // Post-add mantissa/exponent: a carry shifts right once, optionally rounding the dropped bit back in
    always_comb begin
        add_inc = 2'd0;
        add_man = sum[MAN_W-1:0];
`ifdef FP16_ADD_ROUND_EN
        rnd = {1'b0, sum[MAN_W:1]} + {{MAN_W{1'b0}}, sum[0]};
`endif
        if (sum_carry) begin
            add_inc = 2'd1;
            add_man = sum[MAN_W:1];
`ifdef FP16_ADD_ROUND_EN
            if (rnd[MAN_W]) begin
                add_inc = 2'd2;
                add_man = rnd[MAN_W:1];
            end else begin
                add_man = rnd[MAN_W-1:0];
            end
`endif
        end
        add_exp  = {1'b0, e3_q} + {{(EXP_W-1){1'b0}}, add_inc};
        add_ovf  = (e3_q == EXP_INF) || (add_exp >= {1'b0, EXP_INF});
        add_zero = sum_eq || (sum == '0);
    end

    // Control FSM: capture, add, shift-normalise one bit per clock, then hold the packed result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
            special_q   <= 1'b0;
            op_sub_q    <= 1'b0;
            sc1_q       <= 1'b0;
            sc2_q       <= 1'b0;
            e3_q        <= '0;
            mc1_q       <= '0;
            mc2_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        op_sub_q   <= op_sub;
                        sc1_q      <= sc1;
                        sc2_q      <= sc2;
                        e3_q       <= e3;
                        mc1_q      <= mc1;
                        mc2_q      <= mc2;
                        in_ready_q <= 1'b0;
                        state_q    <= ADD;
                    end
                end
                ADD: begin
                    sign_q    <= sum_sign;
                    exp_q     <= add_exp[EXP_W-1:0];
                    man_q     <= add_man;
                    special_q <= add_ovf || add_zero;
                    if (add_ovf) begin
                        result_q <= '{sign: sum_sign, exp: EXP_INF, frac: '0};
                        ovf_q    <= 1'b1;
                    end else if (add_zero) begin
                        // Equal magnitudes of opposite sign cancel to +0
                        result_q <= '{sign: sum_eq ? 1'b0 : sum_sign, exp: '0, frac: '0};
                        zero_q   <= 1'b1;
                    end
                    state_q <= NORM;
                end
                NORM: begin
                    // Overflow/zero results were packed in ADD and bypass normalisation
                    if (special_q || man_q[MAN_W-1]) begin
                        if (!special_q) begin
                            result_q <= '{sign: sign_q, exp: exp_q, frac: man_q[MAN_W-2:0]};
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (exp_q > 1) begin
                        man_q <= man_q << 1;
                        exp_q <= exp_q - 1'b1;
                    end else begin
                        result_q    <= '{sign: sign_q, exp: '0, frac: '0};
                        unf_q       <= 1'b1;
                        zero_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        ovf_q       <= 1'b0;
                        unf_q       <= 1'b0;
                        zero_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fp16_add_norm.sv
// tb/tb_fp16_add_norm.sv - directed self-checking bench for fp16_add_norm
module tb_fp16_add_norm;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic        sc1, sc2;
    logic [4:0]  e3;
    logic [10:0] mc1, mc2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow, underflow, zero;

    int checks = 0;
    int errors = 0;

    fp16_add_norm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .sc1       (sc1),
        .sc2       (sc2),
        .e3        (e3),
        .mc1       (mc1),
        .mc2       (mc2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand set; returns the latency counted from the accepting edge (inclusive)
    task automatic issue(input logic sub, input logic s1, input logic s2, input logic [4:0] e,
                         input logic [10:0] m1, input logic [10:0] m2, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        op_sub = sub; sc1 = s1; sc2 = s2; e3 = e; mc1 = m1; mc2 = m2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic run_vec(input string tag, input logic sub, input logic s1, input logic s2,
                           input logic [4:0] e, input logic [10:0] m1, input logic [10:0] m2,
                           input logic [15:0] exp_res, input logic exp_ovf, input logic exp_unf,
                           input logic exp_zero, input int exp_lat);
        int lat;
        issue(sub, s1, s2, e, m1, m2, lat);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
        chk({tag, "_flags"}, {29'd0, overflow, underflow, zero}, {29'd0, exp_ovf, exp_unf, exp_zero});
        chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_flags_clear"}, {29'd0, overflow, underflow, zero}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
        sc1 = 1'b0; sc2 = 1'b0; e3 = '0; mc1 = '0; mc2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        chk("reset_flags", {29'd0, overflow, underflow, zero}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

        // 1.0+1.0 -> carry, exp 16
        run_vec("t1_add", 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h400, 16'h4000, 1'b0, 1'b0, 1'b0, 3);
        // 1.0-0.5 -> one left shift
        run_vec("t2_sub", 1'b1, 1'b0, 1'b0, 5'd15, 11'h400, 11'h200, 16'h3800, 1'b0, 1'b0, 1'b0, 4);
        // exact cancellation
        run_vec("t3_cancel", 1'b1, 1'b0, 1'b0, 5'd15, 11'h400, 11'h400, 16'h0000, 1'b0, 1'b0, 1'b1, 3);
        // carry into exp 31
        run_vec("t4_ovf", 1'b0, 1'b0, 1'b0, 5'd30, 11'h7FF, 11'h7FF, 16'h7C00, 1'b1, 1'b0, 1'b0, 3);
        // exp already 1, no normalise room
        run_vec("t5_unf", 1'b1, 1'b0, 1'b0, 5'd1, 11'h400, 11'h300, 16'h0000, 1'b0, 1'b1, 1'b1, 3);
`ifdef FP16_ADD_ROUND_EN
        run_vec("t6_round", 1'b0, 1'b0, 1'b0, 5'd15, 11'h401, 11'h400, 16'h4001, 1'b0, 1'b0, 1'b0, 3);
`else
        run_vec("t6_trunc", 1'b0, 1'b0, 1'b0, 5'd15, 11'h401, 11'h400, 16'h4000, 1'b0, 1'b0, 1'b0, 3);
`endif
        // worst case 10 shifts: exp 15-10=5, negative larger operand
        run_vec("t7_max_shift", 1'b1, 1'b1, 1'b1, 5'd15, 11'h400, 11'h3FF, 16'h9400, 1'b0, 1'b0, 1'b0, 13);
        // subtract with op2 larger -> sign of op2 after inversion (negative)
        run_vec("t8_neg", 1'b1, 1'b0, 1'b0, 5'd15, 11'h200, 11'h400, 16'hB800, 1'b0, 1'b0, 1'b0, 4);
        // infinite exponent on input
        run_vec("t9_inf_in", 1'b0, 1'b1, 1'b1, 5'd31, 11'h400, 11'h000, 16'hFC00, 1'b1, 1'b0, 1'b0, 3);

        // backpressure: result held with out_ready low
        issue(1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h400, lat);
        held = result;
        chk("hold_result_first", {16'd0, held}, 32'h4000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", {16'd0, result}, 32'h4000);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_release", {31'd0, out_valid}, 32'd0);

        // reset while normalising
        op_sub = 1'b1; sc1 = 1'b0; sc2 = 1'b0; e3 = 5'd15; mc1 = 11'h400; mc2 = 11'h3FF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_result", {16'd0, result}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk("midreset_no_result", {31'd0, out_valid}, 32'd0);
        run_vec("t10_after_reset", 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h400, 16'h4000, 1'b0, 1'b0, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
